// File: rtl/neogeo_backup_sram_ctrl.sv
// -----------------------------------------------------------------------------
// neogeo_backup_sram_ctrl
//
// Backup-RAM controller between the 68K bus-decode logic and an external
// asynchronous SRAM. Provides a req/ack access port with byte enables,
// WAIT strobe-active cycles per access and a registered read path. An
// optional clear engine fills every SRAM word with FILL after reset or on a
// clear_start pulse.
//
// Optional feature macro: NEOGEO_SRAM_CLEAR_EN
//   defined   : clear runs after reset and on clear_start; busy reports it.
//   undefined : no clear states, clear_start ignored, busy tied low,
//               SRAM contents persist across resets.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   req          access request, held high until ack
//   we           1 = write, 0 = read (sampled with req)
//   be           byte enables, active high (sampled with req)
//   addr         word address (sampled with req)
//   wdata        write data (sampled with req)
//   rdata        read data, valid from the ack cycle until the next read
//   ack          one-cycle completion pulse
//   clear_start  single-cycle clear request
//   busy         clear engine owns the SRAM (or a clear is pending)
//   sram_a       SRAM address
//   sram_dq      SRAM bidirectional data bus
//   sram_oe_n    SRAM output enable, active low
//   sram_we_n    SRAM write enable, active low
//   sram_be_n    SRAM byte-lane selects, active low
// -----------------------------------------------------------------------------
module neogeo_backup_sram_ctrl #(
  parameter int unsigned   AW   = 15,
  parameter int unsigned   DW   = 16,
  parameter int unsigned   WAIT = 2,
  parameter logic [DW-1:0] FILL = {DW{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata,
  output logic              ack,
  input  logic              clear_start,
  output logic              busy,
  output logic [AW-1:0]     sram_a,
  inout  wire  [DW-1:0]     sram_dq,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [DW/8-1:0]   sram_be_n
);

  localparam int unsigned BW      = DW / 8;
  // Wait counter reload value: the state is left when the counter hits 0,
  // so loading WAIT-1 gives exactly WAIT cycles in the state.
  localparam logic [3:0]  WAIT_LD = 4'(WAIT - 1);

`ifdef NEOGEO_SRAM_CLEAR_EN
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACC     = 3'd1,
    ST_REC     = 3'd2,
    ST_CLR_WR  = 3'd3,
    ST_CLR_REC = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_REC  = 2'd2
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  // Registered SRAM-side and host-side outputs
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic [BW-1:0]   be_n_q, be_n_d;
  logic [AW-1:0]   sram_a_q, sram_a_d;
  logic            dq_oe_q, dq_oe_d;
  logic [DW-1:0]   dq_out_q, dq_out_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ack_q, ack_d;

`ifdef NEOGEO_SRAM_CLEAR_EN
  logic            pend_q, pend_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            busy_q, busy_d;
`else
  // Clear inputs have no function in this build.
  logic            unused_s;
  assign unused_s = clear_start ^ (^FILL);
`endif

  // Next-state logic: access sequencing, clear sequencing and field latching
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
`ifdef NEOGEO_SRAM_CLEAR_EN
    pend_d     = pend_q;
    clr_addr_d = clr_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef NEOGEO_SRAM_CLEAR_EN
        // Clear wins over a host request.
        if (pend_q || clear_start) begin
          state_d    = ST_CLR_WR;
          cnt_d      = WAIT_LD;
          clr_addr_d = {AW{1'b0}};
          pend_d     = 1'b0;
        end else if (req) begin
          state_d = ST_ACC;
          cnt_d   = WAIT_LD;
          addr_d  = addr;
          we_d    = we;
          be_d    = be;
          wdata_d = wdata;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (req) begin
          state_d = ST_ACC;
          cnt_d   = WAIT_LD;
          addr_d  = addr;
          we_d    = we;
          be_d    = be;
          wdata_d = wdata;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_REC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`ifdef NEOGEO_SRAM_CLEAR_EN
        // A clear requested mid-access waits for the access to finish.
        pend_d = pend_q | clear_start;
`endif
      end
      ST_REC: begin
        state_d = ST_IDLE;
`ifdef NEOGEO_SRAM_CLEAR_EN
        pend_d = pend_q | clear_start;
`endif
      end
`ifdef NEOGEO_SRAM_CLEAR_EN
      ST_CLR_WR: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CLR_REC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CLR_REC: begin
        // Increment wraps the last address back to 0 naturally.
        clr_addr_d = clr_addr_q + ADDR_ONE;
        if (clr_addr_q == ADDR_MAX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLR_WR;
          cnt_d   = WAIT_LD;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop aligned
  // with the state it belongs to
  always_comb begin
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    be_n_d   = {BW{1'b1}};
    sram_a_d = sram_a_q;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    ack_d    = 1'b0;
    case (state_d)
      ST_ACC: begin
        sram_a_d = addr_d;
        be_n_d   = ~be_d;
        if (we_d) begin
          we_n_d   = 1'b0;
          dq_oe_d  = 1'b1;
          dq_out_d = wdata_d;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      ST_REC: begin
        ack_d = 1'b1;
      end
`ifdef NEOGEO_SRAM_CLEAR_EN
      ST_CLR_WR: begin
        sram_a_d = clr_addr_d;
        be_n_d   = {BW{1'b0}};
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
        dq_out_d = FILL;
      end
`endif
      default: begin
        ack_d = 1'b0;
      end
    endcase

    // Read data is sampled at the end of the last strobe-active cycle.
    if ((state_q == ST_ACC) && (cnt_q == 4'd0) && !we_q) begin
      rdata_d = sram_dq;
    end else begin
      rdata_d = rdata_q;
    end

`ifdef NEOGEO_SRAM_CLEAR_EN
    busy_d = pend_d | (state_d == ST_CLR_WR) | (state_d == ST_CLR_REC);
`endif
  end

  // FSM state, wait counter and latched request fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {AW{1'b0}};
      we_q    <= 1'b0;
      be_q    <= {BW{1'b0}};
      wdata_q <= {DW{1'b0}};
`ifdef NEOGEO_SRAM_CLEAR_EN
      pend_q     <= 1'b1;
      clr_addr_q <= {AW{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
`ifdef NEOGEO_SRAM_CLEAR_EN
      pend_q     <= pend_d;
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  // Output registers; reset forces strobes inactive and the bus released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= {BW{1'b1}};
      sram_a_q <= {AW{1'b0}};
      dq_oe_q  <= 1'b0;
      dq_out_q <= {DW{1'b0}};
      rdata_q  <= {DW{1'b0}};
      ack_q    <= 1'b0;
`ifdef NEOGEO_SRAM_CLEAR_EN
      busy_q   <= 1'b1;
`endif
    end else begin
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      sram_a_q <= sram_a_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
`ifdef NEOGEO_SRAM_CLEAR_EN
      busy_q   <= busy_d;
`endif
    end
  end

  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;
  assign sram_a    = sram_a_q;
  assign sram_dq   = dq_oe_q ? dq_out_q : {DW{1'bz}};
  assign rdata     = rdata_q;
  assign ack       = ack_q;
`ifdef NEOGEO_SRAM_CLEAR_EN
  assign busy      = busy_q;
`else
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_neogeo_backup_sram_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for neogeo_backup_sram_ctrl (AW=4, WAIT=2, FILL=16'hA55A) with a
// behavioural asynchronous SRAM. Read expectations are pushed to a queue when
// a read is issued and popped when ack arrives. Scenarios depend on whether
// NEOGEO_SRAM_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
module tb_neogeo_backup_sram_ctrl;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned WAIT = 2;
  localparam logic [DW-1:0] FILL = 16'hA55A;
  localparam int unsigned DEPTH = 1 << AW;

  logic            clk;
  logic            reset_n;
  logic            req;
  logic            we;
  logic [BW-1:0]   be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            ack;
  logic            clear_start;
  logic            busy;
  logic [AW-1:0]   sram_a;
  wire  [DW-1:0]   sram_dq;
  logic            sram_oe_n;
  logic            sram_we_n;
  logic [BW-1:0]   sram_be_n;

  int tests_run;
  int tests_failed;
  int cyc;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] exp_q [$];

  neogeo_backup_sram_ctrl #(
    .AW(AW), .DW(DW), .WAIT(WAIT), .FILL(FILL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .clear_start(clear_start),
    .busy(busy), .sram_a(sram_a), .sram_dq(sram_dq), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: drives the bus while oe_n is low, writes enabled lanes
  assign sram_dq = (!sram_oe_n) ? sram_mem[sram_a] : {DW{1'bz}};
  always @(posedge clk) begin
    if (!sram_we_n) begin
      for (int l = 0; l < BW; l++) begin
        if (!sram_be_n[l]) sram_mem[sram_a][l*8 +: 8] = sram_dq[l*8 +: 8];
      end
    end
  end

  task automatic fail_msg(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_failed++;
    $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic set_ref_fill();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
  endtask

  // One host access; checks latency, read data and single-cycle ack
  task automatic do_access(input logic w, input logic [BW-1:0] b, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input string tag, output int ack_cyc);
    int lat;
    bit got;
    logic [DW-1:0] exp;
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    if (w) begin
      for (int l = 0; l < BW; l++) if (b[l]) ref_mem[a][l*8 +: 8] = d[l*8 +: 8];
    end else begin
      exp_q.push_back(ref_mem[a]);
    end
    lat = 0; got = 1'b0; ack_cyc = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (ack) got = 1'b1;
    end
    req = 1'b0;
    tests_run++;
    if (!got) begin
      fail_msg({tag, " ack_timeout"}, 32'(lat), 32'(WAIT + 1));
      if (!w) exp = exp_q.pop_front();
    end else begin
      ack_cyc = cyc;
      tests_run++;
      if (lat !== WAIT + 1) fail_msg({tag, " latency"}, 32'(lat), 32'(WAIT + 1));
      if (!w) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (rdata !== exp) fail_msg({tag, " rdata"}, 32'(rdata), 32'(exp));
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (ack !== 1'b0) fail_msg({tag, " ack_width"}, 32'(ack), 32'd0);
  endtask

  task automatic wait_busy_low(input string tag, output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) fail_msg({tag, " busy_stuck"}, 32'(busy), 32'd0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (sram_oe_n !== 1'b1) fail_msg("rst oe_n", 32'(sram_oe_n), 32'd1);
    tests_run++; if (sram_we_n !== 1'b1) fail_msg("rst we_n", 32'(sram_we_n), 32'd1);
    tests_run++; if (sram_be_n !== 2'b11) fail_msg("rst be_n", 32'(sram_be_n), 32'h3);
    tests_run++; if (sram_a !== 4'd0) fail_msg("rst sram_a", 32'(sram_a), 32'd0);
    tests_run++; if (rdata !== 16'h0000) fail_msg("rst rdata", 32'(rdata), 32'd0);
    tests_run++; if (ack !== 1'b0) fail_msg("rst ack", 32'(ack), 32'd0);
`ifdef NEOGEO_SRAM_CLEAR_EN
    tests_run++; if (busy !== 1'b1) fail_msg("rst busy", 32'(busy), 32'd1);
`else
    tests_run++; if (busy !== 1'b0) fail_msg("rst busy", 32'(busy), 32'd0);
`endif
  endtask

  task automatic test_clear_after_reset();
    int n;
    int c;
    @(negedge clk);
    reset_n = 1'b1;
    wait_busy_low("boot_clear", n);
    tests_run++;
    if (n !== 1 + DEPTH * (WAIT + 1)) fail_msg("boot_clear duration", 32'(n), 32'(1 + DEPTH * (WAIT + 1)));
    set_ref_fill();
    for (int i = 0; i < DEPTH; i++) do_access(1'b0, 2'b00, 4'(i), 16'h0000, "boot_clear read", c);
  endtask

  task automatic test_write_read();
    int c;
    do_access(1'b1, 2'b11, 4'd3, 16'h1234, "wr full", c);
    do_access(1'b0, 2'b00, 4'd3, 16'h0000, "rd full", c);
  endtask

  task automatic test_byte_enables();
    int c;
    do_access(1'b1, 2'b01, 4'd3, 16'hFF00, "wr be01", c);
    do_access(1'b0, 2'b00, 4'd3, 16'h0000, "rd be01", c);
    do_access(1'b1, 2'b00, 4'd3, 16'hBEEF, "wr be00", c);
    do_access(1'b0, 2'b00, 4'd3, 16'h0000, "rd be00", c);
    do_access(1'b1, 2'b10, 4'd3, 16'hABCD, "wr be10", c);
    do_access(1'b0, 2'b00, 4'd3, 16'h0000, "rd be10", c);
  endtask

  task automatic test_back_to_back();
    int c1, c2, c3;
    do_access(1'b1, 2'b11, 4'd7, 16'hC0DE, "b2b wr", c1);
    do_access(1'b0, 2'b00, 4'd7, 16'h0000, "b2b rd7", c2);
    do_access(1'b0, 2'b00, 4'd3, 16'h0000, "b2b rd3", c3);
    tests_run++; if (c2 - c1 !== WAIT + 2) fail_msg("b2b spacing1", 32'(c2 - c1), 32'(WAIT + 2));
    tests_run++; if (c3 - c2 !== WAIT + 2) fail_msg("b2b spacing2", 32'(c3 - c2), 32'(WAIT + 2));
  endtask

`ifdef NEOGEO_SRAM_CLEAR_EN
  task automatic test_clear_during_read();
    int n, c;
    logic [DW-1:0] exp;
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 2'b00; addr = 4'd3;
    exp_q.push_back(ref_mem[3]);
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) fail_msg("cdr busy_before", 32'(busy), 32'd0);
    @(negedge clk); clear_start = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b1) fail_msg("cdr busy_rise", 32'(busy), 32'd1);
    tests_run++; if (ack !== 1'b0) fail_msg("cdr early_ack", 32'(ack), 32'd0);
    @(negedge clk); clear_start = 1'b0;
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    tests_run++; if (ack !== 1'b1) fail_msg("cdr ack", 32'(ack), 32'd1);
    tests_run++; if (rdata !== exp) fail_msg("cdr rdata", 32'(rdata), 32'(exp));
    req = 1'b0;
    wait_busy_low("cdr clear", n);
    set_ref_fill();
    do_access(1'b0, 2'b00, 4'd3, 16'h0000, "cdr fill3", c);
    do_access(1'b0, 2'b00, 4'd7, 16'h0000, "cdr fill7", c);
  endtask
`endif

  task automatic test_reset_mid_write();
    int n, c;
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 4'd5; wdata = 16'h5555;
    @(posedge clk); #1;
    tests_run++; if (sram_we_n !== 1'b0) fail_msg("rmw we_active", 32'(sram_we_n), 32'd0);
    reset_n = 1'b0;
    #1;
    req = 1'b0;
    tests_run++; if (sram_we_n !== 1'b1) fail_msg("rmw we_n", 32'(sram_we_n), 32'd1);
    tests_run++; if (sram_oe_n !== 1'b1) fail_msg("rmw oe_n", 32'(sram_oe_n), 32'd1);
    tests_run++; if (sram_be_n !== 2'b11) fail_msg("rmw be_n", 32'(sram_be_n), 32'h3);
    tests_run++; if (ack !== 1'b0) fail_msg("rmw ack", 32'(ack), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`ifdef NEOGEO_SRAM_CLEAR_EN
    tests_run++; if (busy !== 1'b1) fail_msg("rmw busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    tests_run++; if (sram_a !== 4'd0) fail_msg("rmw clr_addr0", 32'(sram_a), 32'd0);
    tests_run++; if (sram_we_n !== 1'b0) fail_msg("rmw clr_we", 32'(sram_we_n), 32'd0);
    wait_busy_low("rmw clear", n);
    tests_run++; if (ack !== 1'b0) fail_msg("rmw no_ack", 32'(ack), 32'd0);
    set_ref_fill();
    do_access(1'b0, 2'b00, 4'd5, 16'h0000, "rmw fill5", c);
    do_access(1'b0, 2'b00, 4'd0, 16'h0000, "rmw fill0", c);
`else
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ((busy !== 1'b0) || (sram_we_n !== 1'b1) || (ack !== 1'b0))
        fail_msg("rmw idle_after", {29'd0, busy, sram_we_n, ack}, 32'h2);
    end
`endif
  endtask

`ifndef NEOGEO_SRAM_CLEAR_EN
  task automatic test_persist();
    int c;
    @(negedge clk); clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ((busy !== 1'b0) || (sram_we_n !== 1'b1))
        fail_msg("persist no_clear", {30'd0, busy, sram_we_n}, 32'h1);
    end
    do_access(1'b0, 2'b00, 4'd3, 16'h0000, "persist rd3", c);
    do_access(1'b0, 2'b00, 4'd7, 16'h0000, "persist rd7", c);
    do_access(1'b0, 2'b00, 4'd0, 16'h0000, "persist rd0", c);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0; req = 1'b0; we = 1'b0; be = 2'b00; addr = 4'd0;
    wdata = 16'h0000; clear_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 16'(i * 257 + 16'h0011);
      ref_mem[i]  = 16'(i * 257 + 16'h0011);
    end

    test_reset();
`ifdef NEOGEO_SRAM_CLEAR_EN
    test_clear_after_reset();
`else
    @(negedge clk); reset_n = 1'b1;
`endif
    test_write_read();
    test_byte_enables();
    test_back_to_back();
`ifdef NEOGEO_SRAM_CLEAR_EN
    test_clear_during_read();
`endif
    test_reset_mid_write();
`ifndef NEOGEO_SRAM_CLEAR_EN
    test_persist();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/neogeo_backup_sram_ctrl.md
# neogeo_backup_sram_ctrl

Parametrised backup-RAM controller for the NeoGeo core, sitting between the 68K bus-decode logic and an external asynchronous SRAM. It provides a req/ack access port with byte enables, programmable access wait states and a registered read path. A sequenced clear engine fills every SRAM word with a known pattern after reset or on request, and a busy flag reports when the clear is running.

## Interface
Parameters:
- AW, 15, word-address width; SRAM depth is 2^AW words.
- DW, 16, data width; must be a multiple of 8.
- WAIT, 2, SRAM strobe-active cycles per access; legal range 1..15.
- FILL, {DW{1'b0}}, word written by the clear engine.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; hold high until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- be  in  DW/8  byte enables, active high; sampled with req.
- addr  in  AW  word address; sampled with req.
- wdata  in  DW  write data; sampled with req.
- rdata  out  DW  read data; valid from the ack cycle until the next read completes.
- ack  out  1  one-cycle completion pulse.
- clear_start  in  1  single-cycle pulse that requests a full clear.
- busy  out  1  high while the clear engine owns the SRAM.
- sram_a  out  AW  SRAM address.
- sram_dq  inout  DW  SRAM data bus.
- sram_oe_n, sram_we_n  out  1  SRAM strobes, active low.
- sram_be_n  out  DW/8  SRAM byte-lane selects, active low.

## Operation
- States: IDLE, ACC, REC, CLR_WR, CLR_REC.
- IDLE: the controller gives clear priority over a request.
  - A pending clear moves the FSM to CLR_WR and resets the clear address to 0.
  - Otherwise, with req high, it latches addr, we, be and wdata and moves to ACC.
- ACC: holds for WAIT cycles.
  - sram_a = latched address.
  - sram_be_n = ~be.
  - Read: sram_oe_n = 0, and rdata is captured on the last ACC cycle.
  - Write: sram_we_n = 0, and sram_dq is driven with the latched wdata.
- REC: one cycle with all strobes high and sram_dq at high-Z. ack pulses in this cycle, then the FSM returns to IDLE.
- CLR_WR: holds for WAIT cycles with sram_we_n = 0, all sram_be_n = 0, sram_dq = FILL and sram_a = clear address.
- CLR_REC: one cycle with strobes high and sram_dq at high-Z.
  - The clear address increments here.
  - If the address was 2^AW−1, the address wraps to 0, busy drops and the FSM goes to IDLE; otherwise it returns to CLR_WR.
- busy is high in CLR_WR and CLR_REC, and while a clear is pending.
- A clear_start pulse that arrives during ACC or REC is latched as pending. The access finishes and acks normally; the clear starts from the following IDLE.
- A clear_start pulse that arrives during an active clear is ignored; the clear does not restart.
- A req that arrives during a clear is not acked; it is served after the clear completes.
- A write with be = 0 still runs a full ACC/REC cycle with all lanes deselected. Memory is unchanged and ack still pulses.
- sram_dq is driven only in write ACC and in CLR_WR. Drivers are never enabled in the same cycle as sram_oe_n = 0.

## Timing
- Access latency: ack is asserted WAIT+1 cycles after the cycle in which req is sampled in IDLE.
- Minimum back-to-back request spacing: WAIT+2 cycles, because IDLE consumes one cycle.
- Clear duration: 2^AW × (WAIT+1) cycles. IDLE→CLR_WR takes one further cycle.
- The wait counter is 4 bits and loads WAIT−1 on state entry; the state exits when the counter reaches 0.
- Reset (asynchronous, at any point including mid-access or mid-clear) drives these values immediately:
  - sram_oe_n = 1, sram_we_n = 1, sram_be_n = all 1.
  - sram_a = 0, sram_dq = high-Z.
  - rdata = 0, ack = 0.
  - FSM = IDLE and the clear address = 0.
  - With NEOGEO_SRAM_CLEAR_EN: clear pending = 1, so busy = 1.
  - Without NEOGEO_SRAM_CLEAR_EN: busy = 0.
- An aborted access never acks.

## Configuration
- NEOGEO_SRAM_CLEAR_EN defined: after reset a full clear runs automatically; clear_start also triggers a clear.
- NEOGEO_SRAM_CLEAR_EN undefined:
  - No clear runs after reset, and clear_start is ignored.
  - busy is tied to 0 and the CLR states are removed.
  - Backup contents persist across resets.

## Test plan
- Macro on, AW=4, WAIT=2, FILL=16'hA55A, reset released → busy stays high for 1+16×3 cycles, then every one of the 16 words reads back 16'hA55A.
- After the clear: write 16'h1234 to addr 3 with be=2'b11, then read addr 3 → each ack arrives 3 cycles after req is sampled, and rdata = 16'h1234.
- Write 16'hFF00 to addr 3 with be=2'b01, then read → rdata = 16'h1200. A write with be=2'b00 leaves the word unchanged but still acks.
- Pulse clear_start in the middle of a read → the read acks with the correct data, busy rises in the next cycle, and the word then reads back as FILL.
- Assert reset_n low during write ACC → the strobes deassert and sram_dq goes to high-Z in the same cycle with no ack; after release the clear restarts from address 0.
- Macro off → busy stays 0 after reset, clear_start has no effect, and data written before the reset is read back intact.
